// File: rtl/button_pkg.sv
// Shared button/LED definitions: debouncer state encoding and the button and LED level constants.
// Imported by the debouncer here and by the LED FSM downstream.
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED      = 2'd0,
        CHECK_PRESS   = 2'd1,
        PRESSED       = 2'd2,
        CHECK_RELEASE = 2'd3
    } btn_state_t;

    localparam logic BTN_PRESSED  = 1'b1;
    localparam logic BTN_RELEASED = 1'b0;

    localparam logic LED_ON  = 1'b1;
    localparam logic LED_OFF = 1'b0;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous pin.
// Two cycles of latency; the reset value is chosen by the caller so the pin reads as idle.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronise, debounce with a stable-count FSM, emit level plus press/release/long-press pulses.
// A stable change reaches btn_level DEBOUNCE_CYCLES+2 edges after first being sampled.
module button_debouncer
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 50000,
    parameter int unsigned LONG_PRESS_CYCLES = 50000000,
    parameter bit          BTN_ACTIVE_HIGH   = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    localparam int DBC_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = (LONG_PRESS_CYCLES == 0) ? 1 : $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DBC_W-1:0]  DBC_DONE  = DBC_W'(DEBOUNCE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = (LONG_PRESS_CYCLES == 0) ? '0 : HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam bit                LP_EN     = (LONG_PRESS_CYCLES != 0);

    logic              btn_norm;
    logic              sync_q;
    btn_state_t        state;
    logic [DBC_W-1:0]  dbc;
    logic [HOLD_W-1:0] hold;
    logic              holding;
    logic              release_accept;

    // Normalise polarity ahead of the synchroniser so everything downstream sees 1 = pressed.
    assign btn_norm = BTN_ACTIVE_HIGH ? btn_raw : ~btn_raw;

    sync_2ff #(
        .RESET_VAL (BTN_RELEASED)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_norm),
        .q     (sync_q)
    );

    assign holding        = (state == PRESSED) || (state == CHECK_RELEASE);
    assign release_accept = (state == CHECK_RELEASE) && (sync_q == BTN_RELEASED) && (dbc == DBC_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= RELEASED;
            dbc           <= '0;
            hold          <= '0;
            btn_level     <= BTN_RELEASED;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;

            // Hold time keeps running through a release check; the threshold is crossed once per press
            // because the counter saturates at LONG_PRESS_CYCLES. A release wins a same-cycle tie.
            if (holding) begin
                if (hold != HOLD_MAX) begin
                    hold <= hold + 1'b1;
                end
                if (LP_EN && (hold == HOLD_FIRE) && !release_accept) begin
                    long_press <= 1'b1;
                end
            end

            case (state)
                RELEASED: begin
                    if (sync_q == BTN_PRESSED) begin
                        state <= CHECK_PRESS;
                        dbc   <= DBC_W'(1);
                    end
                end
                CHECK_PRESS: begin
                    if (sync_q == BTN_RELEASED) begin
                        state <= RELEASED;
                        dbc   <= '0;
                    end else if (dbc == DBC_DONE) begin
                        state       <= PRESSED;
                        btn_level   <= BTN_PRESSED;
                        press_pulse <= 1'b1;
                        hold        <= '0;
                    end else begin
                        dbc <= dbc + 1'b1;
                    end
                end
                PRESSED: begin
                    if (sync_q == BTN_RELEASED) begin
                        state <= CHECK_RELEASE;
                        dbc   <= DBC_W'(1);
                    end
                end
                CHECK_RELEASE: begin
                    if (sync_q == BTN_PRESSED) begin
                        state <= PRESSED;
                        dbc   <= '0;
                    end else if (dbc == DBC_DONE) begin
                        state         <= RELEASED;
                        btn_level     <= BTN_RELEASED;
                        release_pulse <= 1'b1;
                    end else begin
                        dbc <= dbc + 1'b1;
                    end
                end
                default: begin
                    state <= RELEASED;
                    dbc   <= '0;
                end
            endcase
        end
    end

endmodule
